// File: rtl/lcd_serial_responder_if.sv
// Serial link between an LCD-style host and the register responder.
// Signal names follow the responder's pin list so the bus reads like the datasheet.
interface lcd_serial_responder_if;
  logic       i_serialClock;
  logic       i_serialEnable;
  logic       i_rxSerial;
  logic       o_txSerial;
  logic       o_txActive;
  logic       o_regWrite;
  logic [6:0] o_regAddress;
  logic [7:0] o_regData;
  logic       o_frameError;

  modport master (
    output i_serialClock, i_serialEnable, i_rxSerial,
    input  o_txSerial, o_txActive, o_regWrite, o_regAddress, o_regData, o_frameError
  );

  modport slave (
    input  i_serialClock, i_serialEnable, i_rxSerial,
    output o_txSerial, o_txActive, o_regWrite, o_regAddress, o_regData, o_frameError
  );
endinterface

// File: rtl/lcd_serial_responder.sv
// Serial register responder: 16-bit frames (R/W, 7-bit address, 8-bit data)
// against a 128 x 8 register file with one read-only hardware-config location.
module lcd_serial_responder #(
  parameter logic [6:0] HW_CONFIG_ADDRESS = 7'h78,
  parameter logic [7:0] HW_CONFIG_VALUE   = 8'h20,
  parameter int         SYNC_STAGES       = 2
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  lcd_serial_responder_if.slave bus
);

  typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, DONE} stateT;

  stateT state, stateNext;

  logic [SYNC_STAGES-1:0] sclkSync, enSync, rxSync;
  logic [SYNC_STAGES:0]   syncValid;
  logic sclkPrev, enPrev, armed;
  logic sclkS, enS, rxS;
  logic sclkRise, sclkFall, enRise, enFall;

  logic [4:0] bitCnt;
  logic [6:0] rxShift;
  logic [7:0] txShift;
  logic [7:0] servedByte;
  logic [7:0] cmdByte;
  logic [7:0] readByte;
  logic       extraEdges;

  logic [6:0] regAddress;
  logic [7:0] regData;
  logic       regWrite, frameError;
  logic       txActive, txSerial;

  logic [7:0] regs [128];

  assign sclkS = sclkSync[SYNC_STAGES-1];
  assign enS   = enSync[SYNC_STAGES-1];
  assign rxS   = rxSync[SYNC_STAGES-1];

  assign sclkRise = sclkS & ~sclkPrev;
  assign sclkFall = ~sclkS & sclkPrev;
  // A frame may only start once enable has been seen low since reset, so a
  // frame already in flight when reset releases is ignored.
  assign enRise   = armed & enS & ~enPrev;
  assign enFall   = ~enS & enPrev;

  // Last 8 received bits including the one being sampled this cycle; holds
  // the command byte at edge 8 and the write data at edge 16.
  assign cmdByte  = {rxShift, rxS};
  assign readByte = (cmdByte[6:0] == HW_CONFIG_ADDRESS) ? HW_CONFIG_VALUE : regs[cmdByte[6:0]];

  // Input synchronizers, edge-detect history and the re-arm tracker.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      sclkSync  <= '0;
      enSync    <= '0;
      rxSync    <= '0;
      sclkPrev  <= 1'b0;
      enPrev    <= 1'b0;
      syncValid <= '0;
      armed     <= 1'b0;
    end else begin
      sclkSync  <= {sclkSync[SYNC_STAGES-2:0], bus.i_serialClock};
      enSync    <= {enSync[SYNC_STAGES-2:0], bus.i_serialEnable};
      rxSync    <= {rxSync[SYNC_STAGES-2:0], bus.i_rxSerial};
      sclkPrev  <= sclkS;
      enPrev    <= enS;
      syncValid <= {syncValid[SYNC_STAGES-1:0], 1'b1};
      // The reset-cleared chain reads low before it holds real pin values,
      // so only trust enable-low once the chain has filled.
      if (syncValid[SYNC_STAGES] && !enS) armed <= 1'b1;
    end
  end

  // State register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= stateNext;
  end

  // Next-state: enable fall aborts ahead of any coincident serial edge.
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:  if (enRise) stateNext = CMD;
      CMD: begin
        if (enFall) stateNext = IDLE;
        else if (sclkRise && bitCnt == 5'd7) stateNext = cmdByte[7] ? RDATA : WDATA;
      end
      WDATA, RDATA: begin
        if (enFall) stateNext = IDLE;
        else if (sclkRise && bitCnt == 5'd15) stateNext = DONE;
      end
      DONE:  if (enFall) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Outputs: read data is driven only while in the read-data phase.
  always_comb begin
    txActive = (state == RDATA);
    txSerial = txActive & txShift[7];
  end

  // Datapath: bit counting, shifting, register file and result strobes.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      bitCnt     <= '0;
      rxShift    <= '0;
      txShift    <= '0;
      servedByte <= '0;
      extraEdges <= 1'b0;
      regAddress <= '0;
      regData    <= '0;
      regWrite   <= 1'b0;
      frameError <= 1'b0;
      for (int i = 0; i < 128; i++) regs[i] <= '0;
    end else begin
      regWrite   <= 1'b0;
      frameError <= 1'b0;
      if (sclkRise && !enFall) begin
        rxShift <= cmdByte[6:0];
        if (bitCnt != 5'h1f) bitCnt <= bitCnt + 5'd1;
      end
      unique case (state)
        IDLE: begin
          if (enRise) begin
            bitCnt     <= '0;
            extraEdges <= 1'b0;
          end
        end
        CMD: begin
          if (enFall) frameError <= 1'b1;
          else if (sclkRise && bitCnt == 5'd7) begin
            regAddress <= cmdByte[6:0];
            if (cmdByte[7]) begin
              txShift    <= readByte;
              servedByte <= readByte;
            end
          end
        end
        WDATA: begin
          if (enFall) frameError <= 1'b1;
          else if (sclkRise && bitCnt == 5'd15 && regAddress != HW_CONFIG_ADDRESS) begin
            regs[regAddress] <= cmdByte;
            regData          <= cmdByte;
            regWrite         <= 1'b1;
          end
        end
        RDATA: begin
          if (enFall) frameError <= 1'b1;
          else if (sclkRise && bitCnt == 5'd15) regData <= servedByte;
          // The MSB must stay up through edge 9, so the fall between edges 8
          // and 9 is skipped; later falls advance to the next bit.
          else if (sclkFall && bitCnt > 5'd8) txShift <= {txShift[6:0], 1'b0};
        end
        DONE: begin
          if (enFall) frameError <= extraEdges;
          else if (sclkRise) extraEdges <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_txSerial   = txSerial;
  assign bus.o_txActive   = txActive;
  assign bus.o_regWrite   = regWrite;
  assign bus.o_regAddress = regAddress;
  assign bus.o_regData    = regData;
  assign bus.o_frameError = frameError;

endmodule

// File: tb/tb_lcd_serial_responder.sv
// Self-checking bench: bit-banged frames at i_clock/10, write scoreboard,
// and a register model for expected read data.
module tb_lcd_serial_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lcd_serial_responder_if bus();

  lcd_serial_responder #(
    .HW_CONFIG_ADDRESS(7'h78),
    .HW_CONFIG_VALUE  (8'h20),
    .SYNC_STAGES      (2)
  ) dut (
    .i_clock(clk),
    .i_reset(rst),
    .bus    (bus)
  );

  int nChecks = 0;
  int nFails  = 0;
  int wrCnt   = 0;
  int errCnt  = 0;
  logic [14:0] expWrQ [$];
  logic [14:0] expWr;
  logic [7:0]  model [128];

  // Write monitor: every o_regWrite pops the scoreboard and must match it.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_frameError) errCnt++;
      if (bus.o_regWrite) begin
        wrCnt++;
        nChecks++;
        if (expWrQ.size() == 0) begin
          nFails++;
          $display("FAIL unexpected_write addr=%h data=%h required no write", bus.o_regAddress, bus.o_regData);
        end else begin
          expWr = expWrQ.pop_front();
          if ({bus.o_regAddress, bus.o_regData} !== expWr) begin
            nFails++;
            $display("FAIL write_content got addr=%h data=%h required addr=%h data=%h",
                     bus.o_regAddress, bus.o_regData, expWr[14:8], expWr[7:0]);
          end
        end
      end
    end
  end

  function automatic logic [7:0] expRead(input logic [6:0] a);
    return (a == 7'h78) ? 8'h20 : model[a];
  endfunction

  // One frame of nEdges serial clocks; optionally asserts reset after edge resetAt+1.
  task automatic frame(input bit rw, input logic [6:0] addr, input logic [7:0] wd,
                       input int nEdges, input int resetAt,
                       output logic [7:0] rd, output int actErr);
    logic [15:0] w;
    bit readPhase;
    w = {rw, addr, wd};
    rd = '0;
    actErr = 0;
    if (!rw && nEdges >= 16 && resetAt < 0 && addr != 7'h78) begin
      expWrQ.push_back({addr, wd});
      model[addr] = wd;
    end
    @(negedge clk);
    bus.i_serialEnable = 1'b1;
    repeat (5) @(negedge clk);
    for (int i = 0; i < nEdges; i++) begin
      bus.i_rxSerial = (i < 16) ? w[15-i] : 1'b0;
      repeat (5) @(negedge clk);
      if (resetAt < 0 && i < 16) begin
        readPhase = rw && i >= 8;
        if (bus.o_txActive !== readPhase) actErr++;
        if (readPhase) rd[15-i] = bus.o_txSerial;
        else if (bus.o_txSerial !== 1'b0) actErr++;
      end
      if (resetAt >= 0 && i > resetAt && bus.o_txActive !== 1'b0) actErr++;
      bus.i_serialClock = 1'b1;
      if (i == resetAt) begin
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        nChecks++;
        if ({bus.o_txSerial, bus.o_txActive, bus.o_regWrite, bus.o_frameError,
             bus.o_regAddress, bus.o_regData} !== 19'd0) begin
          nFails++;
          $display("FAIL reset_mid_outputs got tx=%b act=%b wr=%b err=%b addr=%h data=%h required all 0",
                   bus.o_txSerial, bus.o_txActive, bus.o_regWrite, bus.o_frameError,
                   bus.o_regAddress, bus.o_regData);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
      end else begin
        repeat (5) @(negedge clk);
      end
      bus.i_serialClock = 1'b0;
    end
    repeat (5) @(negedge clk);
    bus.i_serialEnable = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  // Read frame with full inline checking of data, phase and strobes.
  task automatic doRead(input string name, input logic [6:0] addr);
    logic [7:0] rd;
    int ae, w0, e0;
    logic [7:0] exp;
    exp = expRead(addr);
    w0 = wrCnt;
    e0 = errCnt;
    frame(1'b1, addr, 8'h00, 16, -1, rd, ae);
    nChecks++;
    if (rd !== exp) begin nFails++; $display("FAIL %s_data got %h required %h", name, rd, exp); end
    nChecks++;
    if (ae != 0) begin nFails++; $display("FAIL %s_phase got %0d bad samples required 0", name, ae); end
    nChecks++;
    if (bus.o_regData !== exp || bus.o_regAddress !== addr) begin
      nFails++;
      $display("FAIL %s_regs got addr=%h data=%h required addr=%h data=%h", name, bus.o_regAddress, bus.o_regData, addr, exp);
    end
    nChecks++;
    if (wrCnt != w0 || errCnt != e0 || bus.o_txActive !== 1'b0 || bus.o_txSerial !== 1'b0) begin
      nFails++;
      $display("FAIL %s_idle got wr=%0d err=%0d act=%b tx=%b required 0 0 0 0", name, wrCnt-w0, errCnt-e0, bus.o_txActive, bus.o_txSerial);
    end
  endtask

  // Write frame checking strobe counts against the given expectations.
  task automatic doWrite(input string name, input logic [6:0] addr, input logic [7:0] d,
                         input int nEdges, input int expWr, input int expErr);
    logic [7:0] rd;
    int ae, w0, e0;
    w0 = wrCnt;
    e0 = errCnt;
    frame(1'b0, addr, d, nEdges, -1, rd, ae);
    nChecks++;
    if (wrCnt - w0 != expWr) begin nFails++; $display("FAIL %s_wrcount got %0d required %0d", name, wrCnt-w0, expWr); end
    nChecks++;
    if (errCnt - e0 != expErr) begin nFails++; $display("FAIL %s_errcount got %0d required %0d", name, errCnt-e0, expErr); end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    nChecks++;
    if (bus.o_txSerial !== 1'b0 || bus.o_txActive !== 1'b0) begin
      nFails++; $display("FAIL reset_tx got tx=%b act=%b required 0 0", bus.o_txSerial, bus.o_txActive);
    end
    nChecks++;
    if (bus.o_regWrite !== 1'b0 || bus.o_frameError !== 1'b0) begin
      nFails++; $display("FAIL reset_strobes got wr=%b err=%b required 0 0", bus.o_regWrite, bus.o_frameError);
    end
    nChecks++;
    if (bus.o_regAddress !== 7'h00 || bus.o_regData !== 8'h00) begin
      nFails++; $display("FAIL reset_regs got addr=%h data=%h required 00 00", bus.o_regAddress, bus.o_regData);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_read_hwcfg;
    doRead("read_hwcfg", 7'h78);
  endtask

  task automatic test_write_read;
    doWrite("write_10", 7'h10, 8'h55, 16, 1, 0);
    doRead("read_10", 7'h10);
  endtask

  task automatic test_write_hwcfg;
    doWrite("write_hwcfg", 7'h78, 8'hAA, 16, 0, 0);
    doRead("read_hwcfg_after_write", 7'h78);
  endtask

  task automatic test_abort;
    doWrite("preload_22", 7'h22, 8'h11, 16, 1, 0);
    doWrite("abort_22", 7'h22, 8'hEE, 11, 0, 1);
    doRead("read_22_after_abort", 7'h22);
  endtask

  task automatic test_overlong;
    doWrite("overlong_01", 7'h01, 8'h3C, 18, 1, 1);
    doRead("read_01", 7'h01);
  endtask

  task automatic test_back_to_back;
    logic [6:0] a [4];
    a[0] = 7'h7F;
    for (int i = 1; i < 4; i++) begin
      a[i] = 7'($urandom_range(0, 119));
    end
    for (int i = 0; i < 4; i++) doWrite("b2b_write", a[i], 8'($urandom_range(0, 255)), 16, 1, 0);
    for (int i = 0; i < 4; i++) doRead("b2b_read", a[i]);
  endtask

  task automatic test_reset_mid;
    logic [7:0] rd;
    int ae, w0, e0;
    w0 = wrCnt;
    e0 = errCnt;
    frame(1'b1, 7'h78, 8'h00, 16, 11, rd, ae);
    for (int i = 0; i < 128; i++) model[i] = 8'h00;
    nChecks++;
    if (ae != 0) begin nFails++; $display("FAIL reset_mid_ignored got %0d active samples required 0", ae); end
    nChecks++;
    if (wrCnt != w0 || errCnt != e0) begin
      nFails++; $display("FAIL reset_mid_strobes got wr=%0d err=%0d required 0 0", wrCnt-w0, errCnt-e0);
    end
    doRead("reset_mid_read_hwcfg", 7'h78);
    doRead("reset_mid_read_10_cleared", 7'h10);
  endtask

  initial begin
    bus.i_serialClock  = 1'b0;
    bus.i_serialEnable = 1'b0;
    bus.i_rxSerial     = 1'b0;
    for (int i = 0; i < 128; i++) model[i] = 8'h00;
    test_reset();
    test_read_hwcfg();
    test_write_read();
    test_write_hwcfg();
    test_abort();
    test_overlong();
    test_back_to_back();
    test_reset_mid();
    nChecks++;
    if (expWrQ.size() != 0) begin
      nFails++; $display("FAIL pending_writes got %0d outstanding required 0", expWrQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule

// File: doc/lcd_serial_responder.md
LCD_SERIAL_RESPONDER -- requirements
Module: lcd_serial_responder

Interface
REQ-001 SHALL have parameter HW_CONFIG_ADDRESS, default 'h78, meaning the address of the read-only hardware-config register.
REQ-002 SHALL have parameter HW_CONFIG_VALUE, default 'h20, meaning the constant value returned on reads of HW_CONFIG_ADDRESS.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer depth on the serial inputs (minimum 2).
REQ-004 i_clock  in  1  Single system clock; all logic on its rising edge.
REQ-005 i_reset  in  1  Reset, asynchronous and active-high.
REQ-006 i_serialClock  in  1  Serial clock from the master; idles low.
REQ-007 i_serialEnable  in  1  Transaction frame; high for the whole transaction.
REQ-008 i_rxSerial  in  1  Master-to-responder data.
REQ-009 o_txSerial  out  1  Responder-to-master data; 0 when not driving read data.
REQ-010 o_txActive  out  1  High while the read-data phase drives o_txSerial.
REQ-011 o_regWrite  out  1  One-cycle strobe on each committed write.
REQ-012 o_regAddress  out  7  Address of the last decoded command.
REQ-013 o_regData  out  8  Data of the last committed write or served read.
REQ-014 o_frameError  out  1  One-cycle strobe on a malformed transaction.

Function
REQ-015 Serial inputs SHALL pass through SYNC_STAGES flops, then a one-flop edge detector; the supported serial clock is at most i_clock/8.
REQ-016 A frame SHALL be exactly 16 serial-clock rising edges while enable is high, MSB first: bit 0 R/W (1=read, 0=write), bits 1-7 address, bits 8-15 data.
REQ-017 i_rxSerial SHALL be sampled on each synchronized serial-clock rising edge.
REQ-018 State machine SHALL have states IDLE, CMD, WDATA, RDATA and DONE.
REQ-019 IDLE -> CMD SHALL occur on the synchronized enable rising edge, clearing the bit counter.
REQ-020 CMD SHALL leave on the 8th rising edge: to WDATA if R/W=0, to RDATA if R/W=1; o_regAddress SHALL update at that point.
REQ-021 On entry to RDATA, the shift register SHALL load regs[address] (HW_CONFIG_VALUE for HW_CONFIG_ADDRESS), o_txActive SHALL go high, and o_txSerial SHALL present the MSB within 1 i_clock of the 8th-edge detection.
REQ-022 In RDATA, o_txSerial SHALL shift to the next bit on each synchronized falling edge.
REQ-023 After the 16th rising edge, RDATA SHALL go to DONE, o_txActive SHALL drop, o_txSerial SHALL return to 0, and o_regData SHALL take the served byte.
REQ-024 WDATA SHALL commit on the 16th rising edge: regs[address] <= data, o_regData <= data, one-cycle o_regWrite, then go to DONE.
REQ-025 A write to HW_CONFIG_ADDRESS SHALL be discarded, with no o_regWrite and no o_frameError.
REQ-026 DONE SHALL ignore further serial-clock edges until enable falls, then go to IDLE; extra edges SHALL cause one o_frameError pulse at the enable fall.
REQ-027 Enable falling in CMD, WDATA or RDATA SHALL abort to IDLE with no register change, no o_regWrite, one o_frameError pulse, and o_txActive/o_txSerial cleared on the next cycle.
REQ-028 A rising serial-clock edge coincident with the enable fall SHALL be ignored, with the abort taking priority.
REQ-029 The register file SHALL be 128 x 8; address 127 SHALL be a normal location unless it is HW_CONFIG_ADDRESS, and the bit counter SHALL saturate, never wrap.

Reset
REQ-030 Asserting i_reset SHALL immediately force IDLE and clear the bit counter and shift register.
REQ-031 Asserting i_reset SHALL immediately set o_txSerial, o_txActive, o_regWrite and o_frameError to 0.
REQ-032 Asserting i_reset SHALL immediately set o_regAddress and o_regData to 0, clear all writable registers to 0, and clear the synchronizer flops to 0.
REQ-033 Reset mid-transaction SHALL discard the frame; after release, a frame already in progress SHALL be ignored until enable is seen low, then high again.

Verification
REQ-034 Read 0x78, serial clock i_clock/10 -> o_txSerial shifts out 0x20 (00100000) over edges 9-16; o_txActive high only during that phase; no strobes.
REQ-035 Write 0x55 to 0x10, then read 0x10 -> one o_regWrite with o_regAddress=0x10, o_regData=0x55; read returns 0x55.
REQ-036 Write 0xAA to 0x78, then read 0x78 -> no o_regWrite; read returns 0x20.
REQ-037 Write frame with enable dropped after 11 edges -> one o_frameError, no o_regWrite, target register unchanged.
REQ-038 18-edge write of 0x3C to 0x01 -> write committed at the 16th edge; o_frameError pulses once at the enable fall.
REQ-039 Reset asserted at edge 12 of a read -> all outputs 0 within 1 i_clock; the next full read of 0x78 returns 0x20.
